// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch predictor.
//   bp_state_e : predictor FSM state (INIT sweeps the counter table, RUN serves traffic)
//   weak_t()   : weakly-taken counter value used when (re)initialising the table
package bp_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Weakly-taken value of a ctr_w-bit saturating counter: MSB set, all else clear.
    function automatic int unsigned weak_t(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: combinational saturating up/down counter step.
//   ctr_i : current counter value (CTR_W bits)
//   inc_i : 1 = increment (saturate at all-ones), 0 = decrement (saturate at zero)
//   ctr_o : next counter value
module bp_sat_ctr #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: table of saturating counters indexed by PC (optionally XOR global history).
//   Build option: define GSHARE_HIST_EN to XOR the global history register into the index;
//   without it the predictor is bimodal (index = low PC bits) and no history is kept.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   flush                : re-initialise table (and history), restarting the INIT sweep
//   ready                : high while in RUN
//   pred_valid, pred_pc  : prediction request
//   resp_valid/taken/ctr/idx : one-cycle-later response; idx is echoed back on update
//   upd_valid/idx/taken/mispred : resolved-branch update
//   mispred_cnt          : saturating mispredict counter (cleared only by rst_n)
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned M        = 16,
    parameter int unsigned HIST_LEN = 4,
    parameter int unsigned CTR_W    = 2,
    localparam int unsigned IW      = $clog2(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [N-1:0]     pred_pc,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [CTR_W-1:0] resp_ctr,
    output logic [IW-1:0]    resp_idx,
    input  logic             upd_valid,
    input  logic [IW-1:0]    upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    output logic [15:0]      mispred_cnt
);

    localparam logic [CTR_W-1:0] WEAK_T = CTR_W'(weak_t(CTR_W));

    bp_state_e        state_q, state_d;
    logic [IW-1:0]    sweep_q, sweep_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_taken_q, resp_taken_d;
    logic [CTR_W-1:0] resp_ctr_q, resp_ctr_d;
    logic [IW-1:0]    resp_idx_q, resp_idx_d;
    logic [15:0]      mispred_q, mispred_d;

    // Counter storage: deliberately not reset, the INIT sweep initialises it.
    logic [CTR_W-1:0] ctr_tbl_q [M];

    logic             run;
    logic             pred_fire;
    logic             upd_fire;
    logic [IW-1:0]    pred_idx;
    logic [CTR_W-1:0] upd_ctr_new;
    logic [CTR_W-1:0] byp_ctr;
    logic [CTR_W-1:0] pred_ctr;
    logic             unused_pc;

    assign unused_pc = ^pred_pc[N-1:IW];

    assign run = (state_q == RUN);
    // A flush cycle is treated as the start of re-initialisation: no traffic is accepted.
    assign pred_fire = run & pred_valid & ~flush;
    assign upd_fire  = run & upd_valid & ~flush;

`ifdef GSHARE_HIST_EN
    logic [HIST_LEN-1:0] ghr_q, ghr_d;

    assign pred_idx = pred_pc[IW-1:0] ^ IW'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (flush) begin
            ghr_d = '0;
        end else if (upd_fire) begin
            // Shift outcome in at the LSB; the size cast drops the old MSB.
            ghr_d = HIST_LEN'({ghr_q, upd_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    assign pred_idx = pred_pc[IW-1:0];
`endif

    bp_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_upd_ctr (
        .ctr_i (ctr_tbl_q[upd_idx]),
        .inc_i (upd_taken),
        .ctr_o (upd_ctr_new)
    );

    // Same step applied to the entry being read, used when the update hits that entry.
    bp_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_byp_ctr (
        .ctr_i (ctr_tbl_q[pred_idx]),
        .inc_i (upd_taken),
        .ctr_o (byp_ctr)
    );

    assign pred_ctr = (upd_fire && (upd_idx == pred_idx)) ? byp_ctr : ctr_tbl_q[pred_idx];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                if (flush) begin
                    sweep_d = '0;
                end else if (sweep_q == IW'(M - 1)) begin
                    state_d = RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IW'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_comb begin
        resp_valid_d = pred_fire;
        resp_taken_d = resp_taken_q;
        resp_ctr_d   = resp_ctr_q;
        resp_idx_d   = resp_idx_q;
        if (pred_fire) begin
            resp_taken_d = pred_ctr[CTR_W-1];
            resp_ctr_d   = pred_ctr;
            resp_idx_d   = pred_idx;
        end
    end

    always_comb begin
        mispred_d = mispred_q;
        if (upd_fire && upd_mispred && (mispred_q != 16'hFFFF)) begin
            mispred_d = mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_ctr_q   <= '0;
            resp_idx_q   <= '0;
            mispred_q    <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
            resp_ctr_q   <= resp_ctr_d;
            resp_idx_q   <= resp_idx_d;
            mispred_q    <= mispred_d;
        end
    end

    // Single write port: the INIT sweep owns it, updates use it only in RUN.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            ctr_tbl_q[sweep_q] <= WEAK_T;
        end else if (upd_fire) begin
            ctr_tbl_q[upd_idx] <= upd_ctr_new;
        end
    end

    assign ready       = run;
    assign resp_valid  = resp_valid_q;
    assign resp_taken  = resp_taken_q;
    assign resp_ctr    = resp_ctr_q;
    assign resp_idx    = resp_idx_q;
    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed stimulus with a scoreboard. Each accepted prediction pushes
// its expected {taken, ctr, idx} into a queue; a monitor pops and compares on resp_valid.
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic [1:0]  resp_ctr;
    logic [3:0]  resp_idx;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispred;
    logic [15:0] mispred_cnt;

    gshare_predictor #(
        .N        (32),
        .M        (16),
        .HIST_LEN (4),
        .CTR_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ready       (ready),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .resp_valid  (resp_valid),
        .resp_taken  (resp_taken),
        .resp_ctr    (resp_ctr),
        .resp_idx    (resp_idx),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       taken;
        logic [1:0] ctr;
        logic [3:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] mdl_tbl [16];
    logic [3:0] mdl_ghr;
    int         mdl_mis;
    bit         mdl_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input bit t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        else   return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    function automatic logic [3:0] exp_idx(input logic [31:0] pc);
`ifdef GSHARE_HIST_EN
        return pc[3:0] ^ mdl_ghr;
`else
        return pc[3:0];
`endif
    endfunction

    // PC that lands on table entry idx under the current history.
    function automatic logic [31:0] pc_for(input logic [3:0] idx);
`ifdef GSHARE_HIST_EN
        return {28'h0, idx ^ mdl_ghr};
`else
        return {28'h0, idx};
`endif
    endfunction

    task automatic model_init(input bit clr_mis);
        for (int i = 0; i < 16; i++) mdl_tbl[i] = 2'd2;
        mdl_ghr = 4'h0;
        if (clr_mis) mdl_mis = 0;
        mdl_run = 1'b0;
    endtask

    // One RUN cycle of stimulus; expectations use pre-update table and history.
    task automatic cyc(input bit pv, input logic [31:0] pc, input bit uv,
                       input logic [3:0] uidx, input bit ut, input bit um);
        logic [3:0] idx;
        logic [1:0] c;
        pred_valid  = pv;
        pred_pc     = pc;
        upd_valid   = uv;
        upd_idx     = uidx;
        upd_taken   = ut;
        upd_mispred = um;
        if (mdl_run) begin
            if (pv) begin
                idx = exp_idx(pc);
                c   = mdl_tbl[idx];
                if (uv && uidx == idx) c = sat(c, ut);
                exp_q.push_back('{taken: c[1], ctr: c, idx: idx});
            end
            if (uv) begin
                mdl_tbl[uidx] = sat(mdl_tbl[uidx], ut);
                mdl_ghr = {mdl_ghr[2:0], ut};
                if (um && mdl_mis < 65535) mdl_mis++;
            end
        end
        step();
        pred_valid  = 1'b0;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    // Called in INIT cycle 0; drives traffic that must be ignored, checks the 16-cycle length.
    task automatic wait_init(input string tag);
        check({tag, "_ready_c0"}, {31'h0, ready}, 32'h0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) begin
                pred_valid  = 1'b1;
                pred_pc     = 32'h5;
                upd_valid   = 1'b1;
                upd_idx     = 4'h5;
                upd_taken   = 1'b1;
                upd_mispred = 1'b1;
            end
            step();
            pred_valid  = 1'b0;
            upd_valid   = 1'b0;
            upd_mispred = 1'b0;
        end
        check({tag, "_ready_c15"}, {31'h0, ready}, 32'h0);
        step();
        check({tag, "_ready_c16"}, {31'h0, ready}, 32'h1);
        check({tag, "_mispred_kept"}, {16'h0, mispred_cnt}, mdl_mis);
        mdl_run = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   {31'h0, ready},       32'h0);
        check({tag, "_rvalid"},  {31'h0, resp_valid},  32'h0);
        check({tag, "_rtaken"},  {31'h0, resp_taken},  32'h0);
        check({tag, "_rctr"},    {30'h0, resp_ctr},    32'h0);
        check({tag, "_ridx"},    {28'h0, resp_idx},    32'h0);
        check({tag, "_mispred"}, {16'h0, mispred_cnt}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp actual={t=%0b c=%0d i=0x%0h} required=no response",
                         resp_taken, resp_ctr, resp_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_taken, resp_ctr, resp_idx} !== mon_e) begin
                    failures++;
                    $display("FAIL resp actual={t=%0b c=%0d i=0x%0h} required={t=%0b c=%0d i=0x%0h}",
                             resp_taken, resp_ctr, resp_idx, mon_e.taken, mon_e.ctr, mon_e.idx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        pred_valid  = 1'b0;
        pred_pc     = 32'h0;
        upd_valid   = 1'b0;
        upd_idx     = 4'h0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        model_init(1'b1);
        #3;
        check_reset_outputs("por");
        step();
        step();

        // Release reset; first RUN cycle is cycle 16.
        rst_n = 1'b1;
        wait_init("init");

        // Fresh table: weakly taken.
        cyc(1, 32'h5, 0, 4'h0, 0, 0);

        // Decrement to zero and saturate there.
        cyc(0, 32'h0, 1, 4'h3, 0, 0);
        cyc(1, pc_for(4'h3), 0, 4'h0, 0, 0);
        cyc(0, 32'h0, 1, 4'h3, 0, 0);
        cyc(1, pc_for(4'h3), 0, 4'h0, 0, 0);
        cyc(0, 32'h0, 1, 4'h3, 0, 0);
        cyc(0, 32'h0, 1, 4'h3, 0, 0);
        cyc(1, pc_for(4'h3), 0, 4'h0, 0, 0);

        // Same-cycle predict/update on one entry takes the bypassed value.
        cyc(0, 32'h0, 1, 4'h7, 0, 0);
        cyc(1, pc_for(4'h7), 1, 4'h7, 1, 0);
        cyc(1, pc_for(4'h7), 0, 4'h0, 0, 0);

        // Back-to-back updates to different entries, and a non-colliding same-cycle pair.
        cyc(0, 32'h0, 1, 4'h1, 0, 0);
        cyc(0, 32'h0, 1, 4'h2, 0, 0);
        cyc(0, 32'h0, 1, 4'h1, 0, 0);
        cyc(1, pc_for(4'h1), 0, 4'h0, 0, 0);
        cyc(1, pc_for(4'h2), 1, 4'h4, 1, 0);
        cyc(1, pc_for(4'h4), 0, 4'h0, 0, 0);

        // History T,T,N,T then pc=0x2; also saturates entry 0xA high.
        cyc(0, 32'h0, 1, 4'hA, 1, 1);
        cyc(0, 32'h0, 1, 4'hA, 1, 1);
        cyc(0, 32'h0, 1, 4'hA, 0, 1);
        cyc(0, 32'h0, 1, 4'hA, 1, 1);
        cyc(1, 32'h2, 0, 4'h0, 0, 0);
        cyc(1, pc_for(4'hA), 0, 4'h0, 0, 0);
        check("mispred_after_4", {16'h0, mispred_cnt}, 32'h4);

        // Flush in RUN.
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_init(1'b0);
        wait_init("flush");
        cyc(1, 32'h3, 0, 4'h0, 0, 0);
        cyc(1, 32'h7, 0, 4'h0, 0, 0);
        cyc(1, 32'hA, 0, 4'h0, 0, 0);
        cyc(1, 32'h1, 0, 4'h0, 0, 0);

        // Mispredict counter saturation.
        for (int i = 0; i < 65530; i++) begin
            cyc(0, 32'h0, 1, i[3:0], i[0], 1);
        end
        check("mispred_near_sat", {16'h0, mispred_cnt}, 32'hFFFE);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 32'h0, 1, i[3:0], i[0], 1);
        end
        check("mispred_sat", {16'h0, mispred_cnt}, 32'hFFFF);

        // Leave non-zero response fields, then pulse reset mid-RUN.
        cyc(1, pc_for(4'h5), 0, 4'h0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("run_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init(1'b1);
        for (int i = 0; i < 8; i++) step();
        // Reset again mid-INIT: the full sweep must restart.
        rst_n = 1'b0;
        #1;
        check("init_rst_ready", {31'h0, ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("reinit");
        cyc(1, 32'h5, 0, 4'h0, 0, 0);
        cyc(1, 32'hC, 0, 4'h0, 0, 0);
        step();
        step();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter N, default 32: PC width.
REQ-002 SHALL have parameter M, default 16: counter table entries, power of two, at least 2; IW = log2(M).
REQ-003 SHALL have parameter HIST_LEN, default 4: global history bits, 1 to IW.
REQ-004 SHALL have parameter CTR_W, default 2: saturating counter width, at least 2.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1: request table and history re-initialisation.
REQ-008 SHALL have port ready, output, 1: high when in RUN.
REQ-009 SHALL have port pred_valid, input, 1: prediction request.
REQ-010 SHALL have port pred_pc, input, N: PC of branch to predict.
REQ-011 SHALL have port resp_valid, output, 1: prediction response valid.
REQ-012 SHALL have port resp_taken, output, 1: predicted direction.
REQ-013 SHALL have port resp_ctr, output, CTR_W: counter value used.
REQ-014 SHALL have port resp_idx, output, IW: table index used, returned later on update.
REQ-015 SHALL have port upd_valid, input, 1: resolved-branch update.
REQ-016 SHALL have port upd_idx, input, IW: index from resp_idx.
REQ-017 SHALL have port upd_taken, input, 1: actual outcome.
REQ-018 SHALL have port upd_mispred, input, 1: prediction was wrong.
REQ-019 SHALL have port mispred_cnt, output, 16: saturating mispredict count.

Function
REQ-020 SHALL have two FSM states: INIT and RUN.
REQ-021 INIT SHALL write one entry per cycle with WEAK_T = 2^(CTR_W-1), from index 0 to M-1, then enter RUN; INIT therefore lasts exactly M cycles.
REQ-022 Asserting flush in RUN SHALL enter INIT on the next edge, clear the GHR, and restart the sweep at index 0; flush during INIT SHALL restart the sweep at index 0.
REQ-023 During INIT: ready=0, requests ignored, resp_valid=0, updates dropped.
REQ-024 Index SHALL be pc[IW-1:0] XOR {zero-extend GHR} (see REQ-036).
REQ-025 Latency SHALL be 1 cycle: pred_valid with ready at edge t gives resp_valid=1 in cycle t+1; the response is held only for that cycle.
REQ-026 resp_taken SHALL equal the counter MSB.
REQ-027 Update on upd_valid in RUN: increment saturating at 2^CTR_W-1 if upd_taken, else decrement saturating at 0.
REQ-028 Update SHALL shift upd_taken into GHR LSB, dropping the MSB.
REQ-029 Update with upd_mispred=1 SHALL increment mispred_cnt, saturating at 0xFFFF; flush SHALL NOT clear it.
REQ-030 Predict and update in the same cycle SHALL form the index from the pre-update GHR.
REQ-031 If that index equals upd_idx, the response SHALL carry the post-update counter (bypass).
REQ-032 Updates to different indices in consecutive cycles SHALL all apply; none lost.

Reset
REQ-033 rst_n low SHALL immediately force: state INIT, sweep index 0, GHR 0, resp_valid 0, resp_taken 0, resp_ctr 0, resp_idx 0, mispred_cnt 0, ready 0.
REQ-034 Reset asserted mid-INIT or mid-RUN SHALL restart a full M-cycle INIT after deassertion; table contents are not reset asynchronously.
REQ-035 First RUN cycle SHALL be cycle M after rst_n rises.

Configuration
REQ-036 Macro GSHARE_HIST_EN defined: XOR indexing per REQ-024; undefined: index = pc[IW-1:0] (bimodal) and GHR logic absent, all else unchanged.

Structure
REQ-037 Package bp_pkg SHALL hold the FSM state enum (INIT, RUN) and the counter next-value helper constants (WEAK_T formula).
REQ-038 Sub-module bp_sat_ctr (combinational saturating inc/dec, width CTR_W) SHALL be instantiated for update and bypass paths.

Verification
REQ-039 Release reset, pred_valid at cycle 16 with pc=0x5 -> resp_valid=1 at cycle 17 with resp_ctr=2, resp_taken=1.
REQ-040 Four updates idx 3, taken=0 -> ctr 1 then 0, then stays 0; predict same index -> resp_taken=0, resp_ctr=0.
REQ-041 With GSHARE_HIST_EN: updates taken,taken,not,taken give GHR=0b1101; predict pc=0x2 -> resp_idx=0xF.
REQ-042 Same-cycle predict and update to idx 7 (ctr 1, taken=1) -> resp_ctr=2, resp_taken=1.
REQ-043 Flush in RUN -> ready=0 for 16 cycles, updates ignored, all entries 2 afterwards, mispred_cnt unchanged.
REQ-044 65540 updates with upd_mispred=1 -> mispred_cnt=0xFFFF; rst_n pulse mid-run -> outputs 0, ready after 16 cycles.
